// File: rtl/simple_pkg.sv
// Shared types and encodings for the SIMPLE pipeline (decode and mem/write-back stages).
package simple_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  regidx_t;
  typedef logic [1:0]  memop_t;

  localparam memop_t MW_NONE  = 2'b00;
  localparam memop_t MW_LOAD  = 2'b01;
  localparam memop_t MW_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WB   = 2'b10
  } state_t;

  // 2'b11 is treated as no memory access.
  function automatic logic is_memop(input memop_t op);
    return (op == MW_LOAD) || (op == MW_STORE);
  endfunction

endpackage

// File: rtl/simple_reqtimer.sv
// Wait counter for an outstanding memory request; flags the last allowed cycle.
module simple_reqtimer
  import simple_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [3:0] LAST = 4'(MEM_TIMEOUT - 1);

  logic [3:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) count <= 4'd0;
    else if (enable)       count <= count + 4'd1;
  end

  assign timeout = enable && (count == LAST);

endmodule

// File: rtl/simple_memwb.sv
// Memory-access and write-back stage: one instruction at a time, req/ack data
// memory handshake with timeout, then a single-cycle register-file write.
module simple_memwb
  import simple_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  word_t       aluresult,
  input  logic        writereg,
  input  regidx_t     regaddress,
  input  memop_t      memwrite,
  input  word_t       address,
  input  word_t       storedata,
  output logic        mem_req,
  output logic        mem_we,
  output word_t       mem_addr,
  output word_t       mem_wdata,
  input  word_t       mem_rdata,
  input  logic        mem_ack,
  output logic        writeflag,
  output regidx_t     writetarget,
  output word_t       writeval,
  output logic        mem_err
);

  state_t state, state_next;
  logic   transfer;
  logic   wr_q;
  logic   timeout;
  logic   load_wb;

  assign transfer = in_valid && in_ready;
  // A load that completes and targets a register goes on to write-back.
  assign load_wb  = (state == REQ) && mem_ack && !mem_we && wr_q;

  simple_reqtimer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state != REQ),
    .enable  (state == REQ),
    .timeout (timeout)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (is_memop(memwrite)) state_next = REQ;
          else if (writereg)      state_next = WB;
        end
      end
      REQ: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack)      state_next = load_wb ? WB : IDLE;
        else if (timeout) state_next = IDLE;
      end
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    mem_req   = (state == REQ);
    writeflag = (state == WB);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      writetarget <= '0;
      writeval    <= '0;
      wr_q        <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= (state == REQ) && !mem_ack && timeout;
      if (transfer) begin
        mem_we      <= (memwrite == MW_STORE);
        mem_addr    <= address;
        mem_wdata   <= storedata;
        writetarget <= regaddress;
        wr_q        <= writereg;
        if (!is_memop(memwrite) && writereg) writeval <= aluresult;
      end
      if (load_wb) writeval <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_simple_memwb.sv
// Table-driven bench for simple_memwb with a write-back scoreboard and a
// behavioural memory responder.
module tb_simple_memwb;
  import simple_pkg::*;

  logic    clock = 1'b0;
  logic    reset_n;
  logic    in_valid;
  logic    in_ready;
  word_t   aluresult, address, storedata, mem_addr, mem_wdata, mem_rdata, writeval;
  logic    writereg, mem_req, mem_we, mem_ack, writeflag, mem_err;
  regidx_t regaddress, writetarget;
  memop_t  memwrite;

  simple_memwb #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluresult(aluresult), .writereg(writereg), .regaddress(regaddress),
    .memwrite(memwrite), .address(address), .storedata(storedata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .writeflag(writeflag),
    .writetarget(writetarget), .writeval(writeval), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct { regidx_t rd; word_t val; } wr_t;
  wr_t exp_q[$];

  // Memory responder: ack on the ack_dly-th cycle of a request (0 = never).
  int    ack_dly   = 0;
  word_t rdata_cfg = '0;
  logic  stray_ack = 1'b0;
  int    rc        = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'hF00D;
  end

  always @(negedge clock) begin
    if (stray_ack) begin
      mem_ack = 1'b1;
    end else if (mem_req) begin
      rc++;
      mem_ack = (ack_dly != 0) && (rc == ack_dly);
    end else begin
      rc = 0;
      mem_ack = 1'b0;
    end
    mem_rdata = mem_ack ? rdata_cfg : 16'hF00D;
  end

  // Monitor and scoreboard.
  int    req_cycles = 0, err_cnt = 0, wr_cnt = 0;
  logic  last_we;
  word_t last_addr, last_wdata;

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_req) begin
        req_cycles++;
        last_we    = mem_we;
        last_addr  = mem_addr;
        last_wdata = mem_wdata;
      end
      if (mem_err) err_cnt++;
      if (writeflag) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write target=%0d val=%h", writetarget, writeval);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wb_target", 32'(writetarget), 32'(e.rd));
          chk("wb_value", 32'(writeval), 32'(e.val));
        end
      end
    end
  end

  typedef struct {
    memop_t  mw;
    logic    wreg;
    regidx_t rd;
    word_t   alu, addr, sdata, rdata;
    int      ack;
    logic    exp_wr;
    word_t   exp_val;
    int      exp_req, exp_busy;
    logic    exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic drive(input memop_t mw, input logic wreg, input regidx_t rd,
                       input word_t alu, input word_t addr, input word_t sdata);
    in_valid = 1'b1; memwrite = mw; writereg = wreg; regaddress = rd;
    aluresult = alu; address = addr; storedata = sdata;
  endtask

  task automatic clear_mon();
    req_cycles = 0; err_cnt = 0; wr_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    reset_n = 1'b0; in_valid = 1'b0;
    drive(MW_NONE, 1'b0, 3'd0, '0, '0, '0); in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_writeflag", 32'(writeflag), 0);
    chk("rst_writetarget", 32'(writetarget), 0);
    chk("rst_writeval", 32'(writeval), 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    @(posedge clock); #1 reset_n = 1'b1;

    //            mw     wr rd    alu       addr      sdata     rdata    ack wr exp_val  req busy err
    vecs[0] = '{2'b00, 1, 3'd5, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h1234, 0,  1, 0};
    vecs[1] = '{2'b01, 1, 3'd2, 16'h9999, 16'h0040, 16'h0000, 16'hBEEF, 3, 1, 16'hBEEF, 3,  4, 0};
    vecs[2] = '{2'b10, 1, 3'd6, 16'h7777, 16'hFFFE, 16'h00A5, 16'h0000, 2, 0, 16'h0000, 2,  2, 0};
    vecs[3] = '{2'b01, 1, 3'd1, 16'h0000, 16'h0100, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 15, 15, 1};
    vecs[4] = '{2'b01, 1, 3'd7, 16'h0000, 16'h0102, 16'h0000, 16'h1111, 15, 1, 16'h1111, 15, 16, 0};
    vecs[5] = '{2'b00, 0, 3'd4, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0,  0, 0};
    vecs[6] = '{2'b11, 1, 3'd0, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h00FF, 0,  1, 0};
    vecs[7] = '{2'b01, 0, 3'd3, 16'h0000, 16'h0200, 16'h0000, 16'h2222, 1, 0, 16'h0000, 1,  1, 0};
    vecs[8] = '{2'b10, 0, 3'd3, 16'h0000, 16'h0300, 16'h3333, 16'h0000, 1, 0, 16'h0000, 1,  1, 0};

    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      clear_mon();
      ack_dly = vecs[i].ack; rdata_cfg = vecs[i].rdata;
      drive(vecs[i].mw, vecs[i].wreg, vecs[i].rd, vecs[i].alu, vecs[i].addr, vecs[i].sdata);
      if (vecs[i].exp_wr) exp_q.push_back('{vecs[i].rd, vecs[i].exp_val});
      @(posedge clock); #1 in_valid = 1'b0;
      @(negedge clock);
      busy = 0;
      while (!in_ready && busy < 40) begin busy++; @(negedge clock); end
      #1;
      if (busy == 40) begin checks++; fails++; $display("FAIL v%0d_in_ready_timeout", i); end
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_mem_err", i), 32'(err_cnt), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_req > 0) begin
        chk($sformatf("v%0d_mem_we", i), 32'(last_we), 32'(vecs[i].mw == 2'b10));
        chk($sformatf("v%0d_mem_addr", i), 32'(last_addr), 32'(vecs[i].addr));
        if (vecs[i].mw == 2'b10)
          chk($sformatf("v%0d_mem_wdata", i), 32'(last_wdata), 32'(vecs[i].sdata));
      end
    end

    // Back-to-back stream with in_valid held high: ALU, load, store, no-op.
    @(posedge clock); #1;
    clear_mon();
    ack_dly = 2; rdata_cfg = 16'h5A5A;
    for (int k = 0; k < 4; k++) begin
      int n;
      case (k)
        0: begin drive(MW_NONE,  1'b1, 3'd3, 16'hAAAA, 16'h0000, 16'h0000); exp_q.push_back('{3'd3, 16'hAAAA}); end
        1: begin drive(MW_LOAD,  1'b1, 3'd4, 16'h0000, 16'h0010, 16'h0000); exp_q.push_back('{3'd4, 16'h5A5A}); end
        2:       drive(MW_STORE, 1'b1, 3'd5, 16'h0000, 16'h0020, 16'hC3C3);
        default: drive(MW_NONE,  1'b0, 3'd6, 16'h6666, 16'h0000, 16'h0000);
      endcase
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 40) begin n++; @(negedge clock); end
      if (n == 40) begin checks++; fails++; $display("FAIL b2b_stall_%0d", k); end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clock);
    #1;
    chk("b2b_writes", 32'(wr_cnt), 2);
    chk("b2b_req_cycles", 32'(req_cycles), 4);
    chk("b2b_mem_err", 32'(err_cnt), 0);
    chk("b2b_last_we", 32'(last_we), 1);
    chk("b2b_last_wdata", 32'(last_wdata), 32'h0000C3C3);

    // Reset during an outstanding load: no write, stray ack ignored.
    @(posedge clock); #1;
    clear_mon();
    ack_dly = 0; rdata_cfg = 16'h7E7E;
    drive(MW_LOAD, 1'b1, 3'd2, 16'h0000, 16'h0400, 16'h0000);
    @(posedge clock); #1 in_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("rmid_in_req", 32'(mem_req), 1);
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("rmid_mem_req", 32'(mem_req), 0);
    chk("rmid_in_ready", 32'(in_ready), 1);
    chk("rmid_writeflag", 32'(writeflag), 0);
    @(posedge clock); #1 reset_n = 1'b1; stray_ack = 1'b1;
    @(posedge clock); #1 stray_ack = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rmid_post_writes", 32'(wr_cnt), 0);
    chk("rmid_post_req", 32'(mem_req), 0);
    chk("rmid_post_ready", 32'(in_ready), 1);
    chk("rmid_post_err", 32'(err_cnt), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/simple_memwb.md
# simple_memwb

Memory-access and write-back stage of the SIMPLE pipeline. It is the consuming end of the decode stage's outputs and the producer of the decode stage's register-write inputs. It takes one decoded/executed instruction at a time (ALU result, register target, memory-op code, address, store data), performs any data-memory access over a req/ack handshake, and then issues a single-cycle register-file write (`writeflag`/`writetarget`/`writeval`).

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted (range 1..15).
- `clock` in 1: sole clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: instruction presented.
- `in_ready` out 1: stage can accept; transfer when `in_valid && in_ready`.
- `aluresult` in 16: execute-stage result.
- `writereg` in 1: instruction writes a register.
- `regaddress` in 3: destination register.
- `memwrite` in 2: 00 none, 01 load, 10 store, 11 treated as 00.
- `address` in 16: data-memory address.
- `storedata` in 16: store value.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store, 0 = load.
- `mem_addr` out 16: latched address.
- `mem_wdata` out 16: latched store data.
- `mem_rdata` in 16: load data, valid when `mem_ack` = 1.
- `mem_ack` in 1: one-cycle completion pulse.
- `writeflag` out 1: register write strobe, one cycle.
- `writetarget` out 3: register index.
- `writeval` out 16: register value.
- `mem_err` out 1: one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, REQ, WB.
- IDLE: `in_ready`=1. On transfer, all inputs are latched.
  - `memwrite`=01 or 10: go to REQ.
  - `memwrite`=00/11 with `writereg`=1: `writeval` is loaded with `aluresult`; go to WB.
  - `memwrite`=00/11 with `writereg`=0: stay in IDLE (no-op).
- REQ: `mem_req`=1, `mem_we`=(op==store), `mem_addr`/`mem_wdata` hold the latched values, `in_ready`=0. A 4-bit wait counter increments each REQ cycle.
  - `mem_ack`=1, load with `writereg`=1: `writeval` is loaded with `mem_rdata`; go to WB.
  - `mem_ack`=1, load with `writereg`=0, or a store: go to IDLE.
  - No ack when counter == `MEM_TIMEOUT`-1: pulse `mem_err`, no register write, go to IDLE.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- WB: `writeflag`=1, `writetarget`=latched `regaddress`, `in_ready`=0; go to IDLE next cycle.
- Stores never write the register file, regardless of `writereg`.
- r0 is an ordinary register; a write to target 0 is issued like any other.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `writeflag`=0, `writetarget`=0, `writeval`=0, `mem_err`=0, counter=0.
- All outputs are registered.
- ALU write: accept at cycle N, `writeflag` high at N+1, `in_ready` high again at N+2.
- Load: `mem_req` high from N+1. With ack at cycle M, `writeflag` is high at M+1 and `mem_req` drops at M+1.
- Store: `mem_req` drops the cycle after ack. `in_ready` returns in that same cycle.
- Timeout abort: `mem_err` and `in_ready` are high in the same cycle `mem_req` drops.
- `mem_ack` outside REQ is ignored.
- `reset_n` low mid-access: next edge forces IDLE. `mem_req` and `writeflag` drop and the pending write is discarded.

## Structure
- Shared package `simple_pkg`:
  - memwrite encodings `MW_NONE`=2'b00, `MW_LOAD`=2'b01, `MW_STORE`=2'b10.
  - state typedef {IDLE, REQ, WB}.
  - 16-bit word and 3-bit register-index typedefs (also used by the decode stage).
- Optional single sub-module `simple_reqtimer`: the wait counter with clear/enable and a `timeout` flag. Everything else lives in one module.

## Test plan
- ALU write: `aluresult`=16'h1234, `writereg`=1, `regaddress`=5, `memwrite`=00 → next cycle `writeflag`=1, `writetarget`=5, `writeval`=16'h1234 for exactly one cycle. No `mem_req`.
- Load: `address`=16'h0040, `regaddress`=2; ack after 3 cycles with `mem_rdata`=16'hBEEF → `mem_req` held 3 cycles with `mem_we`=0 and `mem_addr`=16'h0040. `writeflag` follows with value 16'hBEEF to r2.
- Store: `storedata`=16'h00A5, `address`=16'hFFFE, `writereg`=1 → `mem_we`=1 and `mem_wdata`=16'h00A5. Never `writeflag`. `in_ready` returns the cycle after ack.
- Timeout: load, ack never comes, `MEM_TIMEOUT`=15 → `mem_req` high exactly 15 cycles, then one-cycle `mem_err`, no write. Repeat with ack on the 15th cycle → write occurs and `mem_err`=0.
- Reset mid-access: pull `reset_n` low during REQ → next edge `mem_req`=0 and `in_ready`=1. A later ack has no effect and there is no `writeflag`.
- Back-to-back: stream ALU, load, store, no-op with `in_valid` held high → transfers only when `in_ready`=1, writes in order, and no-op produces nothing.
